// File: rtl/rst_req_sched_pkg.sv
// Shared definitions for the soft-reset request scheduler: state encodings,
// default timing and the requester index map.
package rst_req_sched_pkg;

    localparam logic [1:0] RST_SCHED_IDLE       = 2'd0;
    localparam logic [1:0] RST_SCHED_PULSE      = 2'd1;
    localparam logic [1:0] RST_SCHED_WAIT_FINAL = 2'd2;
    localparam logic [1:0] RST_SCHED_COOLDOWN   = 2'd3;

    localparam int RST_SCHED_NUM_REQ         = 4;
    localparam int RST_SCHED_CNT_BITS        = 8;
    localparam int RST_SCHED_PULSE_CYCLES    = 8;
    localparam int RST_SCHED_WAIT_LIMIT      = 255;
    localparam int RST_SCHED_COOLDOWN_CYCLES = 16;

    // Requester slots; a lower index wins arbitration.
    localparam int RST_REQ_WATCHDOG = 0;
    localparam int RST_REQ_DEBUG    = 1;
    localparam int RST_REQ_WB_SOFT  = 2;
    localparam int RST_REQ_EXTERNAL = 3;

    function automatic bit fits_cnt(input int value, input int bits);
        return (value >= 0) && (longint'(value) < (longint'(1) << bits));
    endfunction

endpackage

// File: rtl/rst_req_sched_if.sv
// Request/grant and reset-controller hookup of the scheduler; the scheduler
// is the slave side.
interface rst_req_sched_if
    import rst_req_sched_pkg::*;
#(
    parameter int NUM_REQ = RST_SCHED_NUM_REQ
);
    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] mask_i;
    logic [NUM_REQ-1:0] ack_o;
    logic [NUM_REQ-1:0] cause_o;
    logic               rst_ctrl_reset_o;
    logic               rst_final_i;
    logic               cause_valid_o;
    logic               busy_o;
    logic               timeout_o;

    modport slave (
        input  req_i, mask_i, rst_final_i,
        output ack_o, cause_o, rst_ctrl_reset_o, cause_valid_o, busy_o, timeout_o
    );

    modport master (
        output req_i, mask_i, rst_final_i,
        input  ack_o, cause_o, rst_ctrl_reset_o, cause_valid_o, busy_o, timeout_o
    );
endinterface

// File: rtl/rst_req_sched_prio.sv
// Combinational fixed-priority picker: one-hot of the lowest set request bit.
module rst_req_prio #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);
    logic seen;

    always_comb begin
        grant = '0;
        seen  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = req[i] & ~seen;
            seen     = seen | req[i];
        end
    end
endmodule

// File: rtl/rst_req_sched.sv
// Soft-reset request scheduler: arbitrates reset requests, drives a fixed
// reset pulse, waits for the core to leave reset, then cools down.
module rst_req_sched
    import rst_req_sched_pkg::*;
#(
    parameter int NUM_REQ         = RST_SCHED_NUM_REQ,
    parameter int CNT_BITS        = RST_SCHED_CNT_BITS,
    parameter int PULSE_CYCLES    = RST_SCHED_PULSE_CYCLES,
    parameter int WAIT_LIMIT      = RST_SCHED_WAIT_LIMIT,
    parameter int COOLDOWN_CYCLES = RST_SCHED_COOLDOWN_CYCLES
) (
    input  logic            sys_clock_i,
    input  logic            sys_reset_i,
    rst_req_sched_if.slave  bus
);
    if (PULSE_CYCLES < 1 || !fits_cnt(PULSE_CYCLES, CNT_BITS)) begin : g_bad_pulse
        $error("rst_req_sched: PULSE_CYCLES does not fit the phase counter");
    end
    if (WAIT_LIMIT < 1 || !fits_cnt(WAIT_LIMIT, CNT_BITS)) begin : g_bad_wait
        $error("rst_req_sched: WAIT_LIMIT does not fit the phase counter");
    end
    if (!fits_cnt(COOLDOWN_CYCLES, CNT_BITS)) begin : g_bad_cool
        $error("rst_req_sched: COOLDOWN_CYCLES does not fit the phase counter");
    end

    localparam logic [CNT_BITS-1:0] PULSE_LAST = CNT_BITS'(PULSE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] WAIT_LAST  = CNT_BITS'(WAIT_LIMIT - 1);
    localparam logic [CNT_BITS-1:0] COOL_LAST  =
        CNT_BITS'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);
    // A zero-length cooldown skips the COOLDOWN state entirely.
    localparam logic [1:0] AFTER_WAIT =
        (COOLDOWN_CYCLES == 0) ? RST_SCHED_IDLE : RST_SCHED_COOLDOWN;

    logic [1:0]          state_reg, state_next;
    logic [CNT_BITS-1:0] cnt_reg, cnt_next;
    logic [NUM_REQ-1:0]  ack_reg, ack_next;
    logic [NUM_REQ-1:0]  cause_reg, cause_next;
    logic                cause_valid_reg, cause_valid_next;
    logic                rst_ctrl_reg, rst_ctrl_next;
    logic                busy_reg, busy_next;
    logic                timeout_reg, timeout_next;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  grant;

    assign eligible = bus.req_i & ~bus.mask_i;

    rst_req_prio #(.NUM_REQ(NUM_REQ)) u_prio (
        .req   (eligible),
        .grant (grant)
    );

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        ack_next         = '0;
        cause_next       = cause_reg;
        cause_valid_next = cause_valid_reg;
        rst_ctrl_next    = rst_ctrl_reg;
        timeout_next     = timeout_reg;
        case (state_reg)
            RST_SCHED_IDLE: begin
                if (|grant) begin
                    state_next       = RST_SCHED_PULSE;
                    cnt_next         = '0;
                    ack_next         = grant;
                    cause_next       = grant;
                    cause_valid_next = 1'b1;
                    rst_ctrl_next    = 1'b1;
                end
            end
            RST_SCHED_PULSE: begin
                if (cnt_reg == PULSE_LAST) begin
                    state_next    = RST_SCHED_WAIT_FINAL;
                    cnt_next      = '0;
                    rst_ctrl_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RST_SCHED_WAIT_FINAL: begin
                // Release is checked first so it wins over a same-cycle timeout.
                if (!bus.rst_final_i) begin
                    state_next = AFTER_WAIT;
                    cnt_next   = '0;
                end else if (cnt_reg == WAIT_LAST) begin
                    state_next   = AFTER_WAIT;
                    cnt_next     = '0;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                if (cnt_reg == COOL_LAST) begin
                    state_next = RST_SCHED_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
        endcase
        busy_next = (state_next != RST_SCHED_IDLE);
    end

    always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            state_reg       <= RST_SCHED_PULSE;
            cnt_reg         <= '0;
            ack_reg         <= '0;
            cause_reg       <= '0;
            cause_valid_reg <= 1'b0;
            rst_ctrl_reg    <= 1'b1;
            busy_reg        <= 1'b1;
            timeout_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            ack_reg         <= ack_next;
            cause_reg       <= cause_next;
            cause_valid_reg <= cause_valid_next;
            rst_ctrl_reg    <= rst_ctrl_next;
            busy_reg        <= busy_next;
            timeout_reg     <= timeout_next;
        end
    end

    assign bus.ack_o            = ack_reg;
    assign bus.cause_o          = cause_reg;
    assign bus.cause_valid_o    = cause_valid_reg;
    assign bus.rst_ctrl_reset_o = rst_ctrl_reg;
    assign bus.busy_o           = busy_reg;
    assign bus.timeout_o        = timeout_reg;
endmodule

// File: tb/tb_rst_req_sched.sv
// Directed bench for rst_req_sched: power-on, grant, priority/mask, timeout,
// release/timeout race and asynchronous reset mid-pulse.
module tb_rst_req_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   n;
    int   acks;

    always #5 clk = ~clk;

    rst_req_sched_if #(.NUM_REQ(4)) bus ();

    rst_req_sched #(
        .NUM_REQ(4), .CNT_BITS(8), .PULSE_CYCLES(8),
        .WAIT_LIMIT(255), .COOLDOWN_CYCLES(16)
    ) dut (
        .sys_clock_i (clk),
        .sys_reset_i (rst),
        .bus         (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (bus.busy_o && k < 400) begin
            k++;
            tick();
        end
        chk(tag, 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_i       = 4'b0000;
        bus.mask_i      = 4'b0000;
        bus.rst_final_i = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_ctrl_reset", 32'(bus.rst_ctrl_reset_o), 32'd1);
        chk("rst_ack",        32'(bus.ack_o),            32'd0);
        chk("rst_cause",      32'(bus.cause_o),          32'd0);
        chk("rst_cause_vld",  32'(bus.cause_valid_o),    32'd0);
        chk("rst_busy",       32'(bus.busy_o),           32'd1);
        chk("rst_timeout",    32'(bus.timeout_o),        32'd0);

        // Power-on pulse, core held in reset for 40 cycles after release
        rst = 1'b0;
        n = 0;
        while (bus.rst_ctrl_reset_o && n < 50) begin n++; tick(); end
        chk("por_pulse_len", 32'(n), 32'd8);
        repeat (32) tick();
        chk("por_no_timeout", 32'(bus.timeout_o), 32'd0);
        bus.rst_final_i = 1'b0;
        tick();
        chk("por_busy_cool", 32'(bus.busy_o), 32'd1);
        n = 0;
        while (bus.busy_o && n < 100) begin n++; tick(); end
        chk("por_cooldown_len", 32'(n), 32'd16);
        chk("por_cause_vld", 32'(bus.cause_valid_o), 32'd0);

        // Single request
        bus.req_i = 4'b0100;
        tick();
        chk("single_ack",       32'(bus.ack_o),            32'h4);
        chk("single_cause",     32'(bus.cause_o),          32'h4);
        chk("single_cause_vld", 32'(bus.cause_valid_o),    32'd1);
        chk("single_rst_ctrl",  32'(bus.rst_ctrl_reset_o), 32'd1);
        bus.req_i = 4'b0000;
        n = 0;
        while (bus.rst_ctrl_reset_o && n < 50) begin
            n++;
            tick();
            if (n == 1) chk("single_ack_once", 32'(bus.ack_o), 32'd0);
        end
        chk("single_pulse_len", 32'(n), 32'd8);
        wait_idle("single_idle");

        // A masked request alone is ignored
        bus.mask_i = 4'b0100;
        bus.req_i  = 4'b0100;
        tick();
        chk("masked_ack",  32'(bus.ack_o),  32'd0);
        chk("masked_busy", 32'(bus.busy_o), 32'd0);

        // Priority with mask, held level re-granted after cooldown
        bus.mask_i = 4'b0001;
        bus.req_i  = 4'b1011;
        tick();
        chk("prio_ack",   32'(bus.ack_o),   32'h2);
        chk("prio_cause", 32'(bus.cause_o), 32'h2);
        bus.req_i = 4'b1000;
        acks = 0;
        n = 0;
        while (bus.busy_o && n < 100) begin
            n++;
            tick();
            if (bus.ack_o != 4'b0000) acks++;
        end
        chk("prio_no_queue_ack", 32'(acks), 32'd0);
        chk("prio_seq_len",      32'(n),    32'd25);
        tick();
        chk("prio_regrant_ack",   32'(bus.ack_o),   32'h8);
        chk("prio_regrant_cause", 32'(bus.cause_o), 32'h8);
        bus.req_i  = 4'b0000;
        bus.mask_i = 4'b0000;
        wait_idle("prio_idle");

        // Release sampled on the same cycle the wait counter reaches its limit
        bus.rst_final_i = 1'b1;
        bus.req_i = 4'b0001;
        tick();
        chk("simul_ack", 32'(bus.ack_o), 32'h1);
        bus.req_i = 4'b0000;
        repeat (262) tick();
        chk("simul_busy_wait", 32'(bus.busy_o),    32'd1);
        chk("simul_pre_to",    32'(bus.timeout_o), 32'd0);
        bus.rst_final_i = 1'b0;
        tick();
        chk("simul_timeout", 32'(bus.timeout_o), 32'd0);
        n = 0;
        while (bus.busy_o && n < 100) begin n++; tick(); end
        chk("simul_cooldown_len", 32'(n), 32'd16);

        // Stuck wake-up sequence
        bus.rst_final_i = 1'b1;
        bus.req_i = 4'b0001;
        tick();
        chk("to_ack", 32'(bus.ack_o), 32'h1);
        bus.req_i = 4'b0000;
        n = 0;
        while (!bus.timeout_o && n < 400) begin n++; tick(); end
        chk("to_latency",  32'(n),                    32'd263);
        chk("to_rst_ctrl", 32'(bus.rst_ctrl_reset_o), 32'd0);
        n = 0;
        while (bus.busy_o && n < 100) begin n++; tick(); end
        chk("to_cooldown_len", 32'(n), 32'd16);
        bus.rst_final_i = 1'b0;
        bus.req_i = 4'b0100;
        tick();
        chk("to_next_ack", 32'(bus.ack_o), 32'h4);
        bus.req_i = 4'b0000;
        wait_idle("to_next_idle");
        chk("to_sticky", 32'(bus.timeout_o), 32'd1);

        // Asynchronous reset during the third pulse cycle
        bus.req_i = 4'b0010;
        tick();
        chk("areset_ack", 32'(bus.ack_o), 32'h2);
        bus.req_i = 4'b0000;
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        chk("areset_rst_ctrl",  32'(bus.rst_ctrl_reset_o), 32'd1);
        chk("areset_cause",     32'(bus.cause_o),          32'd0);
        chk("areset_cause_vld", 32'(bus.cause_valid_o),    32'd0);
        chk("areset_busy",      32'(bus.busy_o),           32'd1);
        chk("areset_timeout",   32'(bus.timeout_o),        32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (bus.rst_ctrl_reset_o && n < 50) begin n++; tick(); end
        chk("areset_pulse_len", 32'(n), 32'd8);
        wait_idle("areset_idle");
        chk("areset_cause_vld_end", 32'(bus.cause_valid_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
